// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer controller in front of a dual-port word memory.
// The address MSB selects one of two banks, and each bank holds one frame.
// The producer fills one bank while the consumer drains the other.
// A bank becomes readable only after its last word has been accepted.
module frame_buf_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  out_req,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  frame_done,
  output logic [1:0]            frames_avail,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int PW     = ADDR_WIDTH - 1;
  // Stage 0: read strobe to memory. Stage 1: memory data present. Stage 2: out_valid.
  localparam int STAGES = 2;

  typedef enum logic {W_FILL, W_WAIT} wst_e;

  wst_e            wst_q, wst_d;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      full_q, full_d;
  logic [STAGES:0] vld_pipe_q;

  logic                  mem_wr_en_q, frame_done_q;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_q, mem_rd_addr_q;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, out_data_q;
  logic [1:0]            frames_avail_q;

  logic wr_acc, rd_iss, wr_last, rd_last, rel_other;

  assign wr_acc    = in_valid & in_ready;
  assign rd_iss    = out_req & full_q[rd_bank_q];
  assign wr_last   = wr_acc & (&wr_ptr_q);
  assign rd_last   = rd_iss & (&rd_ptr_q);
  // The reader frees the bank the writer wants next.
  // Seen on the same edge so a coincident completion never stalls.
  assign rel_other = rd_last & (rd_bank_q != wr_bank_q);

  // Write FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wst_q <= W_FILL;
    else        wst_q <= wst_d;
  end

  // Write FSM next state; the bank toggles on leaving a completed frame
  always_comb begin
    wst_d     = wst_q;
    wr_bank_d = wr_bank_q;
    case (wst_q)
      W_FILL: if (wr_last) begin
        if (!full_q[~wr_bank_q] || rel_other) wr_bank_d = ~wr_bank_q;
        else                                  wst_d     = W_WAIT;
      end
      W_WAIT: if (rel_other) begin
        wst_d     = W_FILL;
        wr_bank_d = ~wr_bank_q;
      end
      default: wst_d = W_FILL;
    endcase
  end

  // Write FSM outputs; the producer is held off during reset
  always_comb begin
    in_ready = reset && (wst_q == W_FILL);
  end

  // Pointer, read-bank and frame-full next state
  always_comb begin
    wr_ptr_d  = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_iss ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rd_bank_d = rd_last ? ~rd_bank_q : rd_bank_q;
    full_d    = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  // Bank bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
    end
  end

  // Memory strobes and read-return pipeline; reset drops in-flight reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q     <= '0;
      mem_wr_en_q    <= 1'b1;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      mem_rd_addr_q  <= '0;
      out_data_q     <= '0;
      frame_done_q   <= 1'b0;
      frames_avail_q <= '0;
    end else begin
      vld_pipe_q     <= {vld_pipe_q[STAGES-1:0], rd_iss};
      mem_wr_en_q    <= ~wr_acc;
      frame_done_q   <= rd_last;
      frames_avail_q <= {1'b0, full_d[0]} + {1'b0, full_d[1]};
      if (wr_acc) begin
        mem_wr_addr_q <= {wr_bank_q, wr_ptr_q};
        mem_wr_data_q <= in_data;
      end
      if (rd_iss)        mem_rd_addr_q <= {rd_bank_q, rd_ptr_q};
      if (vld_pipe_q[1]) out_data_q    <= mem_rd_data;
    end
  end

  assign mem_wr_en    = mem_wr_en_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_rd_en    = ~vld_pipe_q[0];
  assign mem_rd_addr  = mem_rd_addr_q;
  assign out_valid    = vld_pipe_q[STAGES];
  assign out_data     = out_data_q;
  assign frame_done   = frame_done_q;
  assign frames_avail = frames_avail_q;

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
Ping-pong frame buffer controller sitting in front of the dual-port data memory (data_mem_alt). It splits the memory into two equal banks, accepts a pixel stream from a producer into one bank and serves a consumer from the other. It swaps banks on whole-frame boundaries and never exposes a partially written frame to the reader.

Parameters:
DATA_WIDTH, 16, pixel/word width; matches memory DATA_WIDTH.
ADDR_WIDTH, 3, memory address width; MSB selects bank, so each bank (frame) holds 2^(ADDR_WIDTH-1) words.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  producer has a word on in_data
in_data  in  DATA_WIDTH  producer pixel
in_ready  out  1  controller accepts in_data this cycle
out_req  in  1  consumer requests the next word (level; one word per cycle)
out_data  out  DATA_WIDTH  pixel returned to consumer
out_valid  out  1  out_data valid this cycle
frame_done  out  1  one-cycle pulse when the last word of a frame is issued to memory for read
frames_avail  out  2  number of complete, unread frames (0..2)
mem_wr_en  out  1  memory write enable, active-low
mem_wr_addr  out  ADDR_WIDTH  memory write address
mem_wr_data  out  DATA_WIDTH  memory write data
mem_rd_en  out  1  memory read enable, active-low
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  memory read data, valid the cycle after memory samples mem_rd_en low

Behaviour:
- Reset (reset low, async): wr_bank=0, rd_bank=0, wr_ptr=0, rd_ptr=0, full[1:0]=0, write FSM=W_FILL. Outputs: mem_wr_en=1, mem_rd_en=1, in_ready=0, out_valid=0, frame_done=0, frames_avail=0, all addr/data outputs 0. In-flight reads are discarded.
- in_ready=1 only when write FSM is W_FILL and reset is deasserted. It is combinational from state.
- Write accept: when in_valid && in_ready at an edge, the next cycle drives mem_wr_en=0, mem_wr_addr={wr_bank,wr_ptr}, mem_wr_data=in_data. The edge also increments wr_ptr. Write latency is 1 cycle and throughput is 1 word/cycle.
- Frame complete: when the accepted word has wr_ptr = all-ones, the controller sets full[wr_bank]=1 and wr_ptr wraps to 0.
  - If full[~wr_bank] is 0, the controller toggles wr_bank and stays in W_FILL.
  - Otherwise it goes to W_WAIT with in_ready=0.
- W_WAIT -> W_FILL, with wr_bank toggled, on the edge where full[~wr_bank] clears.
- Read issue: when out_req && full[rd_bank] at an edge, the next cycle drives mem_rd_en=0, mem_rd_addr={rd_bank,rd_ptr}. The edge also increments rd_ptr.
  - out_valid=1 with out_data=mem_rd_data two cycles after the issuing edge.
  - out_data holds its last value when out_valid=0.
- Read frame end: an issue with rd_ptr = all-ones does the following:
  - clears full[rd_bank];
  - toggles rd_bank;
  - wraps rd_ptr to 0;
  - pulses frame_done high for the cycle in which that last mem_rd_en=0 is driven.
- No read is issued when full[rd_bank]=0, and out_req is ignored in that case. A bank being filled is never readable.
- frames_avail = full[0]+full[1], registered.
- Simultaneous completion and release: if the writer completes its bank on the same edge the reader clears full[~wr_bank], the writer sees the cleared flag. It toggles bank and stays in W_FILL, so in_ready never drops.
- Write and read to the same address on the same cycle cannot occur by construction.
- Reset mid-frame: a partial frame is lost and both banks are reported empty afterwards.

Test Plan:
1. Hold reset low 2 cycles, then release -> all outputs at reset values. in_ready=1 on the first cycle after release; mem_wr_en/mem_rd_en stay 1.
2. ADDR_WIDTH=3, out_req=0, push 0x1..0x4 back-to-back -> memory writes to addr 0,1,2,3 with data 1..4. frames_avail=1 after the 4th accept, in_ready stays 1, and the next words go to addr 4..7.
3. Push 8 words (0x1..0x8), no reads -> frames_avail=2 and in_ready=0 after the 8th accept. A 9th in_valid is not accepted and no memory write occurs.
4. From scenario 3, hold out_req=1 -> reads at addr 0,1,2,3 and out_data 1,2,3,4 on consecutive out_valid cycles, 2 cycles after issue. frame_done pulses with addr 3. in_ready returns to 1 and the next write goes to addr 0. Reads then continue at addr 4..7.
5. out_req=1 with frames_avail=0 for 10 cycles -> mem_rd_en stays 1, out_valid stays 0, frame_done stays 0.
6. Align the writer's last bank-1 word (addr 7) with the reader's last bank-0 read (addr 3) on the same edge -> in_ready never deasserts and the next write goes to addr 0.
7. Assert reset after 2 words of a frame and 1 pending read -> out_valid is 0 immediately and frames_avail=0. After release, the first write lands at addr 0.
